sc_mult_sequencer: RTL and testbench
====================================

// Module: sc_mult_sequencer
// PURPOSE
//  Shares one bipolar stochastic-multiplier datapath (two 31-bit LFSRs, two 4-bit comparators,
//  one XNOR) between two requesters. Grants requesters round-robin, seeds and loads the
//  datapath, and runs it for exactly WINDOW bit-cycles. Counts the ones in the returned
//  stochastic stream, skew-compensating for the datapath pipeline latency, and returns the
//  count with a valid/ready handshake. Sits between the request fabric and the datapath.
// PARAMETERS
//  WINDOW  256      stochastic bits per multiplication; power of 2, 4..4096
//  DP_LAT  2        cycles from dp_run high to the matching dp_sn_bit; range 1..7
//  SEED_A  31'd1    LFSR A seed driven on dp_seed_a; must be nonzero
//  SEED_B  31'd2    LFSR B seed driven on dp_seed_b; nonzero, differs from SEED_A
//  CW      (derived) $clog2(WINDOW)+1, result width; holds WINDOW with no overflow
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rst_n        in   1   synchronous reset, ACTIVE-HIGH despite name
//  req0_valid   in   1   requester 0 has an operand pair
//  req0_prob    in   8   [3:0] operand A prob, [7:4] operand B prob
//  req0_ready   out  1   requester 0 accepted this cycle
//  req1_valid   in   1   requester 1 has an operand pair
//  req1_prob    in   8   as req0_prob
//  req1_ready   out  1   requester 1 accepted this cycle
//  res_valid    out  1   result available
//  res_ready    in   1   consumer takes result
//  res_count    out  CW  number of 1s in the WINDOW-bit product stream
//  res_id       out  1   requester that owns res_count
//  dp_load      out  1   one-cycle pulse: datapath loads seeds and probs
//  dp_seed_a    out  31  SEED_A (constant)
//  dp_seed_b    out  31  SEED_B (constant)
//  dp_prob      out  8   registered prob of the granted request
//  dp_run       out  1   datapath advances LFSRs and emits one bit per cycle
//  dp_sn_bit    in   1   XNOR product bit, valid DP_LAT cycles after its dp_run cycle
//  busy         out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset (1 cycle sufficient, any state): state=IDLE; all outputs 0 (dp_seed_* constant).
//    Count, run counter, id and DP_LAT sample pipe cleared; last_grant=1, so req0 wins first.
//  - FSM: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: reqX_ready is combinational. Exactly one ready goes high, and only if that reqX_valid is high.
//    If both are valid, grant the requester != last_grant. Accept when valid&&ready: capture prob into
//    dp_prob and id into res_id; -> LOAD. reqX_ready is 0 in every state except IDLE.
//  - LOAD (1 cycle): dp_load=1; count=0; run counter=0; -> RUN.
//  - RUN (exactly WINDOW cycles): dp_run=1. On the last cycle (counter==WINDOW-1) -> DRAIN.
//  - Sampling: sample pipe = dp_run delayed DP_LAT cycles. Each cycle the delayed bit is 1 and
//    dp_sn_bit=1, count += 1. dp_sn_bit is ignored at all other times.
//  - DRAIN (exactly DP_LAT cycles): dp_run=0; sampling continues; -> DONE.
//  - DONE: res_valid=1. res_count/res_id stable until res_valid&&res_ready; then last_grant=res_id, -> IDLE.
//  - Latency: accept edge = cycle 0; LOAD = cycle 1; RUN = 2..WINDOW+1;
//    res_valid first high at cycle WINDOW+DP_LAT+2.
//  - Width: count is CW bits; the max value WINDOW is representable, so there is no wrap or saturation.
//  - Requests arriving while busy stall (ready=0). A valid may drop before acceptance with no effect.
//  - Bipolar decode (2*count/WINDOW-1) is downstream, not here.
// TESTING  (WINDOW=16, DP_LAT=2, datapath stub echoes a programmed bit pattern delayed 2)
//  1. Reset; req0_valid, prob=8'h88; stub sn=1 always -> dp_load at cyc1, dp_run cyc2..17;
//     res_valid cyc20 with count=16 (5'h10), id=0.
//  2. Same with stub sn=0 always -> count=0. Drive sn=1 outside the delayed-run window -> count still 0.
//  3. req0 and req1 valid continuously, res_ready=1 -> grants 0,1,0,1; res_id matches each time.
//  4. Stub returns the run-index LSB (alternating) -> count=8. This checks the DP_LAT alignment.
//  5. Hold res_ready=0 for 5 cycles in DONE -> res_valid, count, id stable; both reqX_ready=0.
//  6. Assert rst_n for 1 cycle mid-RUN -> next cycle dp_run=0, busy=0, res_valid=0. A fresh req1
//     with sn=1 then returns count=16 and id=1, with no stale samples.

Source files
------------

// File: rtl/sc_mult_sequencer.sv
// sc_mult_sequencer
// Round-robin arbiter and sequencer for a shared bipolar stochastic-multiplier
// datapath. Grants one of two requesters, loads and runs the datapath for
// WINDOW bit-cycles, counts the returned ones with the pipeline skew removed,
// and presents the count to a valid/ready consumer.
module sc_mult_sequencer #(
    parameter int          WINDOW = 256,
    parameter int          DP_LAT = 2,
    parameter logic [30:0] SEED_A = 31'd1,
    parameter logic [30:0] SEED_B = 31'd2,
    localparam int         CW     = $clog2(WINDOW) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [7:0]    req0_prob,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_prob,
    output logic          req1_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_count,
    output logic          res_id,
    output logic          dp_load,
    output logic [30:0]   dp_seed_a,
    output logic [30:0]   dp_seed_b,
    output logic [7:0]    dp_prob,
    output logic          dp_run,
    input  logic          dp_sn_bit,
    output logic          busy
);

    localparam int               RCW        = $clog2(WINDOW);
    localparam logic [RCW-1:0]   RUN_LAST   = RCW'(WINDOW - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(DP_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [RCW-1:0]    run_cnt;
    logic [2:0]        drain_cnt;
    logic [CW-1:0]     count;
    logic [DP_LAT-1:0] sample_pipe;
    logic              last_grant;
    logic              accept;
    logic              grant_id;

    assign dp_seed_a = SEED_A;
    assign dp_seed_b = SEED_B;
    assign res_count = count;
    assign busy      = (state != IDLE);

    // State register; reset forces the sequence back to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode, including the round-robin grant in IDLE.
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        dp_load    = 1'b0;
        dp_run     = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant)) begin
                    req0_ready = 1'b1;
                    accept     = 1'b1;
                    grant_id   = 1'b0;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    accept     = 1'b1;
                    grant_id   = 1'b1;
                end
                if (accept) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                dp_load    = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                dp_run = 1'b1;
                if (run_cnt == RUN_LAST) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Delay dp_run by the datapath latency so each returned bit lines up with its run cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sample_pipe <= '0;
        end else begin
            sample_pipe[0] <= dp_run;
            for (int i = 1; i < DP_LAT; i++) begin
                sample_pipe[i] <= sample_pipe[i-1];
            end
        end
    end

    // Operand capture, run/drain counters, ones counter and round-robin history.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count      <= '0;
            run_cnt    <= '0;
            drain_cnt  <= '0;
            res_id     <= 1'b0;
            dp_prob    <= '0;
            last_grant <= 1'b1;
        end else begin
            if (sample_pipe[DP_LAT-1] && dp_sn_bit) begin
                count <= count + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_prob <= grant_id ? req1_prob : req0_prob;
                        res_id  <= grant_id;
                    end
                end
                LOAD: begin
                    count     <= '0;
                    run_cnt   <= '0;
                    drain_cnt <= '0;
                end
                RUN: begin
                    run_cnt <= run_cnt + RCW'(1);
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                end
                DONE: begin
                    if (res_ready) begin
                        last_grant <= res_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mult_sequencer.sv
// tb_sc_mult_sequencer
// Directed and randomized bench for sc_mult_sequencer with WINDOW=16, DP_LAT=2.
// A datapath stub replays a programmed bit pattern two cycles behind dp_run and
// drives noise outside that window.
module tb_sc_mult_sequencer;

    localparam int WIN = 16;
    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [7:0]  req0_prob;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_prob;
    logic        req1_ready;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_count;
    logic        res_id;
    logic        dp_load;
    logic [30:0] dp_seed_a;
    logic [30:0] dp_seed_b;
    logic [7:0]  dp_prob;
    logic        dp_run;
    logic        dp_sn_bit;
    logic        busy;

    int checks;
    int failures;

    // Stub and model state
    logic [15:0] pattern;
    logic        noise;
    logic        noise_rand;
    int          run_idx;
    logic [1:0]  hist_v;
    logic [1:0]  hist_b;
    logic        model_last;

    sc_mult_sequencer #(
        .WINDOW(WIN),
        .DP_LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_prob (req0_prob),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_prob (req1_prob),
        .req1_ready(req1_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_id    (res_id),
        .dp_load   (dp_load),
        .dp_seed_a (dp_seed_a),
        .dp_seed_b (dp_seed_b),
        .dp_prob   (dp_prob),
        .dp_run    (dp_run),
        .dp_sn_bit (dp_sn_bit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stub: the bit for the k-th run cycle appears two cycles after that cycle.
    initial begin
        hist_v    = 2'b00;
        hist_b    = 2'b00;
        run_idx   = 0;
        dp_sn_bit = 1'b0;
    end
    always @(negedge clk) begin
        if (hist_v[1]) dp_sn_bit = hist_b[1];
        else           dp_sn_bit = noise_rand ? 1'($urandom_range(0, 1)) : noise;
        if (dp_load) run_idx = 0;
        hist_v = {hist_v[0], dp_run};
        hist_b = {hist_b[0], dp_run ? pattern[run_idx[3:0]] : 1'b0};
        if (dp_run) run_idx++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction from IDLE through result handshake, checked against the model.
    task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] p0,
                                 input logic [7:0] p1, input logic [15:0] pat, input int hold);
        logic       exp_id;
        logic [7:0] exp_prob;
        int         cyc;
        int         runs;
        int         first_run;
        pattern    = pat;
        req0_valid = r0;
        req1_valid = r1;
        req0_prob  = p0;
        req1_prob  = p1;
        res_ready  = 1'b0;
        exp_id     = (r0 && r1) ? ~model_last : r1;
        exp_prob   = exp_id ? p1 : p0;
        #1;
        checkOutput("ready0_idle", {31'd0, req0_ready}, {31'd0, exp_id == 1'b0});
        checkOutput("ready1_idle", {31'd0, req1_ready}, {31'd0, exp_id == 1'b1});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("load_pulse", {31'd0, dp_load}, 32'd1);
        checkOutput("dp_prob", {24'd0, dp_prob}, {24'd0, exp_prob});
        checkOutput("busy_load", {31'd0, busy}, 32'd1);
        cyc       = 1;
        runs      = 0;
        first_run = 0;
        while (!res_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (dp_run) begin
                runs++;
                if (first_run == 0) first_run = cyc;
            end
        end
        checkOutput("first_run_cycle", first_run, 2);
        checkOutput("run_cycles", runs, WIN);
        checkOutput("valid_cycle", cyc, WIN + LAT + 2);
        checkOutput("count", {27'd0, res_count}, $countones(pat));
        checkOutput("id", {31'd0, res_id}, {31'd0, exp_id});
        for (int h = 0; h < hold; h++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput("hold_valid", {31'd0, res_valid}, 32'd1);
            checkOutput("hold_count", {27'd0, res_count}, $countones(pat));
            checkOutput("hold_id", {31'd0, res_id}, {31'd0, exp_id});
            checkOutput("hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk); #1;
        res_ready  = 1'b0;
        model_last = exp_id;
        checkOutput("after_hs_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("after_hs_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_prob  = 8'h00;
        req1_prob  = 8'h00;
        res_ready  = 1'b0;
        pattern    = 16'h0000;
        noise      = 1'b0;
        noise_rand = 1'b0;
        model_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;

        // Reset state
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_outs", {27'd0, res_valid, dp_load, dp_run, req0_ready, req1_ready}, 32'd0);
        checkOutput("rst_count", {27'd0, res_count}, 32'd0);
        checkOutput("rst_id", {31'd0, res_id}, 32'd0);
        checkOutput("rst_prob", {24'd0, dp_prob}, 32'd0);
        checkOutput("seed_a", {1'b0, dp_seed_a}, 32'd1);
        checkOutput("seed_b", {1'b0, dp_seed_b}, 32'd2);

        // All-ones stream, then all-zeros with ones driven outside the window
        applyStimulus(1'b1, 1'b0, 8'h88, 8'h00, 16'hFFFF, 0);
        noise = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h88, 8'h00, 16'h0000, 0);

        // Both requesters contending: grants alternate
        noise_rand = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 16'($urandom), 0);
        end

        // Alternating stream exposes sample alignment
        applyStimulus(1'b0, 1'b1, 8'h5A, 8'hA5, 16'hAAAA, 0);

        // Consumer backpressure in DONE
        applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 16'($urandom), 5);

        // Random requester mixes
        for (int i = 0; i < 4; i++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(1, 3));
            applyStimulus(sel[0], sel[1], 8'($urandom), 8'($urandom), 16'($urandom), 0);
        end

        // Reset mid-RUN, then a fresh req1 must see no stale samples
        pattern    = 16'hFFFF;
        req0_valid = 1'b1;
        req0_prob  = 8'h33;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("mid_run", {31'd0, dp_run}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_last = 1'b1;
        checkOutput("rst_mid_run", {31'd0, dp_run}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_valid", {31'd0, res_valid}, 32'd0);
        noise_rand = 1'b0;
        noise      = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00, 8'hC3, 16'hFFFF, 0);

        $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
